// File: rtl/vram_pkg.sv
// Shared definitions for the video RAM arbiter: default bus widths and CPU-side state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_pkg;

    localparam int VRAM_ADDR_W = 13;   // 8 KB: 4 KB text/attributes + 4 KB 8x16 font
    localparam int VRAM_DATA_W = 8;

    // CPU access sequencing; the display path has no state of its own.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // a new CPU request may be taken
        S_RDATA = 2'd1,   // RAM read data returning this cycle
        S_ACK   = 2'd2    // cpu_ack high for exactly this cycle
    } vram_state_t;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted write buffer for CPU writes into video RAM, with address match for read forwarding.
// Latency: load visible on wb_valid/wb_address/wb_data the cycle after load; hit is combinational.
// Backpressure: none internally; load wins over drain in the same cycle (drain-and-refill).
// Ports: load/load_address/load_data capture a write; drain empties the entry;
//        match_address is compared full-width against the held address to produce hit.
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clock_25,
    input  logic              reset_n,
    input  logic              load,
    input  logic              drain,
    input  logic [ADDR_W-1:0] load_address,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] match_address,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_address,
    output logic [DATA_W-1:0] wb_data,
    output logic              hit
);

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid   <= 1'b0;
            wb_address <= '0;
            wb_data    <= '0;
        end else if (load) begin
            wb_valid   <= 1'b1;
            wb_address <= load_address;
            wb_data    <= load_data;
        end else if (drain) begin
            wb_valid   <= 1'b0;
        end
    end

    assign hit = wb_valid && (wb_address == match_address);

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video RAM between the display fetcher (always first) and the CPU.
// Latency: display data 1 cycle after disp_req; CPU write/forwarded read ack +1, RAM read ack +2 after issue.
// Backpressure: CPU held via req/ack; display never stalls, so continuous disp_req starves the CPU.
// Ports: disp_* display read port; cpu_* req/ack CPU port; wb_empty reports an empty write buffer;
//        ram_* drive the synchronous single-port RAM (read data returns one cycle after address).
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clock_25,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_address,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              wb_empty,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    vram_state_t       state;
    logic [ADDR_W-1:0] address_hold;   // last address driven, kept on idle cycles

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_address;
    logic [DATA_W-1:0] wb_data;
    logic              wb_hit;

    logic idle_req;
    logic rd_forward;
    logic rd_issue;
    logic wb_drain;
    logic wr_accept;

    always_comb begin
        idle_req   = (state == S_IDLE) && cpu_req;
        rd_forward = idle_req && !cpu_we && wb_hit;
        // A read needing RAM takes the first display-free slot, ahead of a drain;
        // with no buffer hit the addresses differ, so the reorder is invisible.
        rd_issue   = idle_req && !cpu_we && !wb_hit && !disp_req;
        wb_drain   = wb_valid && !disp_req && !rd_issue;
        // A full buffer can still accept if it empties into RAM this same cycle.
        wr_accept  = idle_req && cpu_we && (!wb_valid || wb_drain);
    end

    always_comb begin
        ram_address = address_hold;
        ram_we      = 1'b0;
        if (disp_req) begin
            ram_address = disp_address;
        end else if (rd_issue) begin
            ram_address = cpu_address;
        end else if (wb_valid) begin
            ram_address = wb_address;
            ram_we      = 1'b1;
        end
    end

    assign ram_wdata = wb_data;
    assign disp_data = ram_rdata;
    assign wb_empty  = !wb_valid;

    vram_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clock_25      (clock_25),
        .reset_n       (reset_n),
        .load          (wr_accept),
        .drain         (wb_drain),
        .load_address  (cpu_address),
        .load_data     (cpu_wdata),
        .match_address (cpu_address),
        .wb_valid      (wb_valid),
        .wb_address    (wb_address),
        .wb_data       (wb_data),
        .hit           (wb_hit)
    );

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            address_hold <= '0;
        end else begin
            address_hold <= ram_address;
            cpu_ack      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_forward) begin
                        cpu_rdata <= wb_data;
                        cpu_ack   <= 1'b1;
                        state     <= S_ACK;
                    end else if (wr_accept) begin
                        cpu_ack   <= 1'b1;
                        state     <= S_ACK;
                    end else if (rd_issue) begin
                        state     <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    cpu_rdata <= ram_rdata;
                    cpu_ack   <= 1'b1;
                    state     <= S_ACK;
                end
                S_ACK: begin
                    // The finishing request may still be high here; it must not restart.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous video RAM between the display fetcher (CGA text/font reads) and the CPU bus.
- Video RAM is 8 KB: 4 KB text/attributes plus 4 KB font 8x16.
- The display always has priority and keeps a fixed 1-cycle read latency.
- CPU accesses use a req/ack handshake, a one-entry posted write buffer with read forwarding, and CPU reads scheduled into free slots.

Parameters:
- ADDR_W, 13, video RAM address width.
- DATA_W, 8, video RAM data width.

Ports:
- clock_25  in  1  pixel/system clock; all logic on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- disp_req  in  1  display needs RAM this cycle.
- disp_address  in  ADDR_W  display read address.
- disp_data  out  DATA_W  display read data, valid the cycle after disp_req.
- cpu_req  in  1  CPU request; held with stable address/data until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_address  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- wb_empty  out  1  write buffer empty (CPU polls before mode switch).
- ram_address  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, 1 cycle after address.

Behaviour:
- Clock and reset: one clock, clock_25. Reset reset_n is asynchronous, active-low.
- Reset values: cpu_ack=0, cpu_rdata=0, wb_valid=0 (wb_empty=1), state=S_IDLE.
- Reset during an operation discards any pending write and any in-flight read; no ack is issued.
- RAM port mux: combinational from disp_req, registered state and write-buffer contents. Per-cycle priority:
  1. disp_req=1 -> ram_address=disp_address, ram_we=0.
  2. Pending CPU read, no buffer hit -> ram_address=cpu_address, ram_we=0; state goes to S_RDATA.
  3. wb_valid=1 -> ram_address=wb_addr, ram_wdata=wb_data, ram_we=1; wb_valid clears.
  4. Otherwise -> ram_we=0, ram_address holds its previous value.
- disp_data = ram_rdata passed straight through; display latency is unchanged.
- States:
  - S_IDLE: a CPU request is considered only here.
  - S_RDATA: RAM data is returning. cpu_rdata<=ram_rdata, cpu_ack<=1, go to S_ACK. The RAM port is free this cycle for the display or a drain.
  - S_ACK: cpu_ack=1 for exactly this cycle. cpu_req is ignored (the old request is ending). Return to S_IDLE.
- Write in S_IDLE: accepted if wb_valid=0, or the buffer drains this same cycle. Latch addr/data, set wb_valid, cpu_ack<=1, go to S_ACK.
  - Ack is visible 1 cycle after the request.
  - Buffer full and not draining -> wait.
- Read in S_IDLE:
  - If wb_valid and wb_addr==cpu_address: forward. cpu_rdata<=wb_data, ack visible next cycle, no RAM access.
  - Otherwise the read issues in the first cycle with disp_req=0. Ack is visible 2 cycles after issue.
  - A read takes the slot before a drain. The addresses differ (no buffer hit), so ordering is safe.
- Display read of an address being drained in the same cycle returns the old byte. This is accepted (one-pixel artefact at most).
- Continuous disp_req starves the CPU indefinitely. No timeout; the fetcher guarantees gaps (text mode uses 3 of every 8 cycles).
- Widths: all address compares are full ADDR_W. There is no wrap or arithmetic.

Decomposition:
- Package vram_pkg: ADDR_W/DATA_W defaults, state encoding S_IDLE/S_RDATA/S_ACK.
- One sub-module, vram_wbuf: one-entry write buffer with load/drain controls, wb_valid, address match output and forwarded data.

Test Plan:
- Reset with reset_n=0 mid-read (state S_RDATA) -> cpu_ack stays 0, wb_empty=1 after release, no RAM write.
- disp_req=1 every cycle, disp_address=0x0A0, RAM[0x0A0]=0x41 -> disp_data=0x41 one cycle later; CPU read held pending with no ack.
- CPU write 0x1F to 0x0001 with disp_req=0 -> ack at cycle+1; ram_we=1 with address 0x0001 and data 0x1F at the next free cycle; wb_empty returns to 1.
- CPU write 0x55 to 0x1234 while disp_req=1 for 10 cycles, then read 0x1234 -> read forwarded, cpu_rdata=0x55, ack 1 cycle after request, no RAM read issued.
- CPU read 0x0800 with RAM[0x0800]=0x3C and disp_req pattern 1,1,0 -> read issues at cycle 2, cpu_ack=1 with cpu_rdata=0x3C at cycle 4.
- Two back-to-back writes (0x10 to 0x0002, 0x20 to 0x0003) with disp_req=1 throughout, then disp_req=0 -> second write ack waits for the drain; RAM receives 0x0002=0x10 before 0x0003=0x20.
